// File: rtl/spectrum_bar_gen.sv
// Spectrum bar generator: snapshots 16 FFT bands per frame, converts each to a
// 4-bit log level, applies attack/decay smoothing and peak-hold, publishes atomically.
module spectrum_bar_gen #(
  parameter int NBANDS       = 16,
  parameter int DW           = 16,
  parameter int HW           = 4,
  parameter int DECAY_FRAMES = 4,
  parameter int PEAK_HOLD    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NBANDS-1:0][DW-1:0]    i_data,
  input  logic                         i_data_done,
  output logic [NBANDS-1:0][HW-1:0]    o_height,
  output logic [NBANDS-1:0][HW-1:0]    o_peak,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic [7:0]                   o_overrun
);

  localparam int IW = (NBANDS > 1) ? $clog2(NBANDS) : 1;
  localparam int FW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_OUT} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [FW-1:0] fc;
  logic [DW-1:0] snap [NBANDS];
  logic [HW-1:0] h_w  [NBANDS];
  logic [HW-1:0] p_w  [NBANDS];
  logic [7:0]    hc   [NBANDS];

  logic [DW-1:0] cur, neg;
  logic [DW-2:0] mag;
  logic [HW-1:0] lvl, h_cur, h_dec, h_new, p_cur, p_dec, p_new;
  logic [7:0]    hc_cur, hc_new;
  logic          tick, last;

  assign tick   = (fc == FW'(DECAY_FRAMES - 1));
  assign last   = (idx == IW'(NBANDS - 1));
  assign o_busy = (state != S_IDLE);

  // Per-band datapath for the band currently addressed by idx
  always_comb begin
    cur = snap[idx];
    neg = -cur;
    if (cur == {1'b1, {(DW-1){1'b0}}})
      mag = '1;
    else if (cur[DW-1])
      mag = neg[DW-2:0];
    else
      mag = cur[DW-2:0];

    lvl = '0;
    for (int unsigned b = 0; b < DW - 1; b++)
      if (mag[b]) lvl = HW'(b + 1);

    h_cur  = h_w[idx];
    p_cur  = p_w[idx];
    hc_cur = hc[idx];
    h_dec  = h_cur - HW'(1);
    p_dec  = p_cur - HW'(1);

    if (lvl >= h_cur)
      h_new = lvl;
    else if (tick)
      h_new = (h_dec > lvl) ? h_dec : lvl;
    else
      h_new = h_cur;

    // Falling peak is floored at the new height so it never drops below the bar
    if (lvl >= p_cur) begin
      p_new  = lvl;
      hc_new = 8'(PEAK_HOLD);
    end else if (hc_cur != '0) begin
      p_new  = p_cur;
      hc_new = hc_cur - 8'd1;
    end else begin
      p_new  = (p_dec > h_new) ? p_dec : h_new;
      hc_new = hc_cur;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_data_done) state_nx = S_PROC;
      S_PROC:  if (last) state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx       <= '0;
      fc        <= '0;
      o_height  <= '0;
      o_peak    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= '0;
      for (int unsigned b = 0; b < NBANDS; b++) begin
        snap[b] <= '0;
        h_w[b]  <= '0;
        p_w[b]  <= '0;
        hc[b]   <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      if (i_data_done && (state != S_IDLE) && (o_overrun != 8'hFF))
        o_overrun <= o_overrun + 8'd1;
      case (state)
        S_IDLE: begin
          if (i_data_done) begin
            for (int unsigned b = 0; b < NBANDS; b++) snap[b] <= i_data[b];
            idx <= '0;
          end
        end
        S_PROC: begin
          h_w[idx] <= h_new;
          p_w[idx] <= p_new;
          hc[idx]  <= hc_new;
          if (!last) idx <= idx + IW'(1);
        end
        S_OUT: begin
          for (int unsigned b = 0; b < NBANDS; b++) begin
            o_height[b] <= h_w[b];
            o_peak[b]   <= p_w[b];
          end
          o_valid <= 1'b1;
          fc      <= tick ? '0 : fc + FW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
